// File: rtl/time_display_pkg.sv
// Shared constants for the four-digit time display: segment patterns,
// anode patterns, field limits and the tens/ones split helper.
package time_display_pkg;

  // Active-low {g,f,e,d,c,b,a}; entry [n] is digit n.
  localparam logic [9:0][6:0] SEG_DIGIT = {
    7'b0010000, // 9
    7'b0000000, // 8
    7'b1111000, // 7
    7'b0000010, // 6
    7'b0010010, // 5
    7'b0011001, // 4
    7'b0110000, // 3
    7'b0100100, // 2
    7'b1111001, // 1
    7'b1000000  // 0
  };
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Entry [idx] is the active-low anode pattern; idx 0 is the leftmost digit.
  localparam logic [3:0][3:0] AN_PAT   = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
  localparam logic [3:0]      AN_BLANK = 4'b1111;

  localparam logic [4:0] MAX_HOURS  = 5'd23;
  localparam logic [5:0] MAX_MINSEC = 6'd59;

  typedef struct packed {
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       show_sec;
  } snap_t;

  function automatic logic [3:0] tens_of(input logic [5:0] v);
    if      (v >= 6'd60) return 4'd6;
    else if (v >= 6'd50) return 4'd5;
    else if (v >= 6'd40) return 4'd4;
    else if (v >= 6'd30) return 4'd3;
    else if (v >= 6'd20) return 4'd2;
    else if (v >= 6'd10) return 4'd1;
    else                 return 4'd0;
  endfunction

  function automatic logic [3:0] ones_of(input logic [5:0] v);
    logic [5:0] t6;
    t6 = {2'b00, tens_of(v)};
    return 4'(v - t6 * 6'd10);
  endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational digit-to-segment decoder; dash flag overrides the digit.
module seven_seg_decode
  import time_display_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_dash,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (i_dash)
      o_seg = SEG_DASH;
    else if (i_digit <= 4'd9)
      o_seg = SEG_DIGIT[i_digit];
  end

endmodule

// File: rtl/time_display.sv
// Four-digit multiplexed seven-segment time display with a per-frame
// snapshot of hours/minutes/seconds.
module time_display
  import time_display_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] hours,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic       show_seconds,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int             PW      = $clog2(SCAN_DIV);
  localparam logic [PW-1:0]  PRE_MAX = PW'(SCAN_DIV - 1);

  logic [PW-1:0] r_pre;
  logic [1:0]    r_idx;
  logic          r_active;
  snap_t         r_snap;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;

  logic       w_tick, w_frame;
  logic [1:0] w_idx_nxt;
  snap_t      w_snap_nxt;
  logic [5:0] w_left, w_right, w_val;
  logic       w_left_bad, w_right_bad, w_dash;
  logic [3:0] w_digit;
  logic [6:0] w_seg;
  logic       w_dp_nxt;

  assign w_tick     = (r_pre == PRE_MAX);
  assign w_frame    = w_tick && (r_idx == 2'd3);
  assign w_idx_nxt  = r_idx + 2'd1;
  assign w_snap_nxt = w_frame ? snap_t'({hours, minutes, seconds, show_seconds}) : r_snap;

  // Outputs are computed from the post-edge idx and snapshot so a fresh
  // capture is already visible on digit 0 of the new frame.
  assign w_left      = w_snap_nxt.show_sec ? w_snap_nxt.minutes : {1'b0, w_snap_nxt.hours};
  assign w_left_bad  = w_snap_nxt.show_sec ? (w_snap_nxt.minutes > MAX_MINSEC)
                                           : (w_snap_nxt.hours > MAX_HOURS);
  assign w_right     = w_snap_nxt.show_sec ? w_snap_nxt.seconds : w_snap_nxt.minutes;
  assign w_right_bad = (w_right > MAX_MINSEC);

  assign w_val   = w_idx_nxt[1] ? w_right : w_left;
  assign w_dash  = w_idx_nxt[1] ? w_right_bad : w_left_bad;
  assign w_digit = w_idx_nxt[0] ? ones_of(w_val) : tens_of(w_val);

  seven_seg_decode u_dec (
    .i_digit (w_digit),
    .i_dash  (w_dash),
    .o_seg   (w_seg)
  );

  assign w_dp_nxt = !((w_idx_nxt == 2'd1) && !w_snap_nxt.seconds[0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre    <= '0;
      r_idx    <= 2'd3;
      r_active <= 1'b0;
      r_snap   <= '0;
      r_an     <= AN_BLANK;
      r_seg    <= SEG_BLANK;
      r_dp     <= 1'b1;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + PW'(1);
      if (w_tick) begin
        r_idx  <= w_idx_nxt;
        r_snap <= w_snap_nxt;
        if (w_frame)
          r_active <= 1'b1;
        if (w_frame || r_active) begin
          r_an  <= AN_PAT[w_idx_nxt];
          r_seg <= w_seg;
          r_dp  <= w_dp_nxt;
        end
      end
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule

// File: tb/tb_time_display.sv
// Directed bench for time_display with SCAN_DIV=4; one frame is 16 cycles.
module tb_time_display;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] hours = 5'd13;
  logic [5:0] minutes = 6'd7;
  logic [5:0] seconds = 6'd42;
  logic       show_seconds = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int nrun = 0;
  int nfail = 0;

  localparam logic [6:0] SG [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [3:0] ANP [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  time_display #(.SCAN_DIV(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .hours        (hours),
    .minutes      (minutes),
    .seconds      (seconds),
    .show_seconds (show_seconds),
    .an           (an),
    .seg          (seg),
    .dp           (dp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] ea, input logic [6:0] es, input logic ed);
    nrun++;
    assert (an === ea) else begin
      nfail++; $error("FAIL %s an got %b exp %b", tag, an, ea);
    end
    nrun++;
    assert (seg === es) else begin
      nfail++; $error("FAIL %s seg got %b exp %b", tag, seg, es);
    end
    nrun++;
    assert (dp === ed) else begin
      nfail++; $error("FAIL %s dp got %b exp %b", tag, dp, ed);
    end
  endtask

  // Advance n cycles on the falling edge, checking digit d every cycle.
  task automatic chk_dig(input string tag, input int d, input logic [6:0] es, input logic edp, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      chk($sformatf("%s d%0d", tag, d), ANP[d], es, edp);
    end
  endtask

  task automatic chk_blank_start(input string tag);
    chk({tag, " t0"}, 4'b1111, BLANK, 1'b1);
    for (int c = 1; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("%s t%0d", tag, c), 4'b1111, BLANK, 1'b1);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset", 4'b1111, BLANK, 1'b1);
    reset = 1'b0;

    // 13:07, seconds 42 (even -> colon on)
    chk_blank_start("blank");
    chk_dig("f0", 0, SG[1], 1'b1, 4);
    chk_dig("f0", 1, SG[3], 1'b0, 4);
    chk_dig("f0", 2, SG[0], 1'b1, 4);
    chk_dig("f0", 3, SG[7], 1'b1, 4);

    // Change one cycle before the frame-start tick: visible on the next edge.
    show_seconds = 1'b1; seconds = 6'd59; minutes = 6'd0;
    chk_dig("mmss", 0, SG[0], 1'b1, 4);
    show_seconds = 1'b0; hours = 5'd24;
    chk_dig("mmss", 1, SG[0], 1'b1, 4);
    chk_dig("mmss", 2, SG[5], 1'b1, 4);
    chk_dig("mmss", 3, SG[9], 1'b1, 4);

    // hours=24 -> left dashes; 00 minutes
    chk_dig("h24", 0, DASH, 1'b1, 4);
    chk_dig("h24", 1, DASH, 1'b1, 4);
    hours = 5'd5; minutes = 6'd63; seconds = 6'd58;
    chk_dig("h24", 2, SG[0], 1'b1, 4);
    chk_dig("h24", 3, SG[0], 1'b1, 4);

    // minutes=63 -> right dashes
    chk_dig("m63", 0, SG[0], 1'b1, 4);
    chk_dig("m63", 1, SG[5], 1'b0, 4);
    hours = 5'd9; minutes = 6'd12; seconds = 6'd10;
    chk_dig("m63", 2, DASH, 1'b1, 4);
    chk_dig("m63", 3, DASH, 1'b1, 4);

    // 09:12, minutes bumped to 13 while idx==1
    chk_dig("m12", 0, SG[0], 1'b1, 4);
    chk_dig("m12", 1, SG[9], 1'b0, 2);
    minutes = 6'd13;
    chk_dig("m12", 1, SG[9], 1'b0, 2);
    chk_dig("m12", 2, SG[1], 1'b1, 4);
    chk_dig("m12", 3, SG[2], 1'b1, 4);

    chk_dig("m13", 0, SG[0], 1'b1, 4);
    chk_dig("m13", 1, SG[9], 1'b0, 4);
    chk_dig("m13", 2, SG[1], 1'b1, 1);

    // Asynchronous reset mid-digit: blank before any clock edge.
    reset = 1'b1;
    #1;
    chk("async_rst", 4'b1111, BLANK, 1'b1);
    repeat (2) @(negedge clk);
    chk("rst_hold", 4'b1111, BLANK, 1'b1);
    reset = 1'b0;

    chk_blank_start("blank2");
    chk_dig("f0b", 0, SG[0], 1'b1, 4);
    chk_dig("f0b", 1, SG[9], 1'b0, 4);
    chk_dig("f0b", 2, SG[1], 1'b1, 4);
    chk_dig("f0b", 3, SG[3], 1'b1, 4);

    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end

endmodule
